// File: rtl/rom_rd_pkg.sv
// rom_rd_pkg: shared definitions for the boot/BASIC ROM reader.
//   - ROM pin widths (19-bit byte address, 8-bit data).
//   - Controller state encodings (IDLE / ACC / REC / PFA).
//   - ROM page bases in 16 KB units, plus a helper that turns a page number
//     into a byte address.
package rom_rd_pkg;

   localparam int unsigned ROM_ADDR_W = 19;
   localparam int unsigned ROM_DATA_W = 8;

   // Controller states.
   localparam logic [1:0] StIdle = 2'd0;  // waiting for a request
   localparam logic [1:0] StAcc  = 2'd1;  // demand access, rom_ce_n low
   localparam logic [1:0] StRec  = 2'd2;  // recovery gap, rom_ce_n high
   localparam logic [1:0] StPfa  = 2'd3;  // sequential prefetch access

   // ROM page numbers, 16 KB each.
   localparam logic [1:0] BAS48  = 2'd0;
   localparam logic [1:0] TRDOS  = 2'd1;
   localparam logic [1:0] BAS128 = 2'd2;
   localparam logic [1:0] GLUK   = 2'd3;

   localparam int unsigned PAGE_SHIFT = 14;

   function automatic logic [ROM_ADDR_W-1:0] page_base(input logic [1:0] page);
      logic [ROM_ADDR_W-1:0] base;
      base = ROM_ADDR_W'(page) << PAGE_SHIFT;
      return base;
   endfunction

endpackage

// File: rtl/rom_rd_timer.sv
// rom_rd_timer: 4-bit loadable down-counter with a zero flag.
// Shared by the access (ACC/PFA) and recovery (REC) phases of rom_reader.
//   fclk        in   clock
//   rst_n       in   asynchronous active-low reset
//   load_i      in   load load_val_i on this edge (overrides counting)
//   load_val_i  in   value to load
//   zero_o      out  counter is zero
// The counter decrements every clock until it reaches zero, then holds.
module rom_rd_timer (
   input  logic       fclk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   output logic       zero_o
);

   logic [3:0] count_q;
   logic [3:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != 4'd0) begin
         count_d = count_q - 4'd1;
      end
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 4'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == 4'd0);

endmodule

// File: rtl/rom_reader.sv
// rom_reader: initiator-side controller for the asynchronous parallel boot ROM.
// Accepts byte reads from the memory arbiter, drives the ROM pins with
// programmable access/recovery timing and keeps a one-byte sequential
// prefetch buffer so linear opcode fetches return with 1-cycle latency.
//   fclk      in   system clock
//   rst_n     in   asynchronous active-low reset
//   req       in   read request; transfer on an edge where req && ready
//   req_addr  in   byte address, sampled with req
//   inval     in   1-cycle pulse clearing the prefetch buffer
//   ready     out  controller can accept a request this cycle
//   rd_valid  out  1-cycle pulse, rd_data holds the requested byte
//   rd_data   out  read data, held until the next rd_valid
//   rom_addr  out  ROM address pins (registered)
//   rom_ce_n  out  ROM chip enable, active low (registered)
//   rom_data  in   ROM data pins, valid after ACC_CYC clocks of ce_n low
module rom_reader
   import rom_rd_pkg::*;
#(
   parameter int unsigned ADDR_W   = ROM_ADDR_W,
   parameter int unsigned ACC_CYC  = 4,
   parameter int unsigned GAP_CYC  = 1,
   parameter int unsigned PREFETCH = 1
) (
   input  logic                  fclk,
   input  logic                  rst_n,
   input  logic                  req,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic                  inval,
   output logic                  ready,
   output logic                  rd_valid,
   output logic [ROM_DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0]     rom_addr,
   output logic                  rom_ce_n,
   input  logic [ROM_DATA_W-1:0] rom_data
);

   localparam logic [3:0]        ACC_LOAD = 4'(ACC_CYC - 1);
   localparam logic [3:0]        GAP_LOAD = 4'(GAP_CYC - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   logic [1:0]            state_q,     state_d;
   logic [ADDR_W-1:0]     rom_addr_q,  rom_addr_d;
   logic                  rom_ce_n_q,  rom_ce_n_d;
   logic                  rd_valid_q,  rd_valid_d;
   logic [ROM_DATA_W-1:0] rd_data_q,   rd_data_d;
   logic [ROM_DATA_W-1:0] pf_buf_q,    pf_buf_d;
   logic [ADDR_W-1:0]     pf_addr_q,   pf_addr_d;
   logic                  pf_valid_q,  pf_valid_d;
   logic                  pend_q,      pend_d;       // aborted prefetch left a demand
   logic [ADDR_W-1:0]     pend_addr_q, pend_addr_d;
   logic                  pf_hit_q,    pf_hit_d;     // demand waits on running prefetch
   logic                  pf_next_q,   pf_next_d;    // REC should launch a prefetch
   logic                  pf_drop_q,   pf_drop_d;    // inval seen during this prefetch

   logic                  tmr_load;
   logic [3:0]            tmr_val;
   logic                  tmr_zero;

   logic                  accept;
   logic                  hit;
   logic                  pf_match;
   logic                  pf_take;

   rom_rd_timer u_timer (
      .fclk       (fclk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   // While a demand is parked on the running prefetch, further requests are held
   // off so that response cannot be lost to an abort.
   assign ready    = (state_q == StIdle) || ((state_q == StPfa) && !pf_hit_q);
   assign accept   = req && ready;
   // inval on the same edge wins over a buffer hit.
   assign hit      = pf_valid_q && !inval && (req_addr == pf_addr_q);
   assign pf_match = (req_addr == rom_addr_q);
   assign pf_take  = pf_hit_q || (accept && pf_match);

   always_comb begin
      state_d     = state_q;
      rom_addr_d  = rom_addr_q;
      rom_ce_n_d  = rom_ce_n_q;
      rd_valid_d  = 1'b0;
      rd_data_d   = rd_data_q;
      pf_buf_d    = pf_buf_q;
      pf_addr_d   = pf_addr_q;
      pf_valid_d  = pf_valid_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      pf_hit_d    = pf_hit_q;
      pf_next_d   = pf_next_q;
      pf_drop_d   = pf_drop_q;
      tmr_load    = 1'b0;
      tmr_val     = ACC_LOAD;

      if (inval) begin
         pf_valid_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               rom_ce_n_d = 1'b0;
               tmr_load   = 1'b1;
               tmr_val    = ACC_LOAD;
               if (hit) begin
                  // Serve from the buffer and immediately fetch the next byte.
                  rd_data_d  = pf_buf_q;
                  rd_valid_d = 1'b1;
                  rom_addr_d = req_addr + ADDR_ONE;
                  pf_valid_d = 1'b0;
                  pf_drop_d  = 1'b0;
                  state_d    = StPfa;
               end else begin
                  rom_addr_d = req_addr;
                  state_d    = StAcc;
               end
            end
         end

         StAcc: begin
            if (tmr_zero) begin
               rd_data_d  = rom_data;
               rd_valid_d = 1'b1;
               rom_ce_n_d = 1'b1;
               tmr_load   = 1'b1;
               tmr_val    = GAP_LOAD;
               pf_next_d  = (PREFETCH != 0);
               state_d    = StRec;
            end
         end

         StRec: begin
            if (tmr_zero) begin
               if (pend_q) begin
                  pend_d     = 1'b0;
                  pf_next_d  = 1'b0;
                  rom_addr_d = pend_addr_q;
                  rom_ce_n_d = 1'b0;
                  tmr_load   = 1'b1;
                  tmr_val    = ACC_LOAD;
                  state_d    = StAcc;
               end else if (pf_next_q) begin
                  pf_next_d  = 1'b0;
                  rom_addr_d = rom_addr_q + ADDR_ONE;
                  rom_ce_n_d = 1'b0;
                  pf_valid_d = 1'b0;
                  pf_drop_d  = 1'b0;
                  tmr_load   = 1'b1;
                  tmr_val    = ACC_LOAD;
                  state_d    = StPfa;
               end else begin
                  state_d    = StIdle;
               end
            end
         end

         StPfa: begin
            if (inval) begin
               pf_drop_d = 1'b1;
            end
            if (tmr_zero) begin
               rom_ce_n_d = 1'b1;
               tmr_load   = 1'b1;
               tmr_val    = GAP_LOAD;
               state_d    = StRec;
               pf_hit_d   = 1'b0;
               if (!pf_drop_q && !inval) begin
                  pf_buf_d   = rom_data;
                  pf_addr_d  = rom_addr_q;
                  pf_valid_d = 1'b1;
               end
               // A demand for the prefetched byte counts as a hit: deliver it
               // and chain the next prefetch after recovery.
               if (pf_take) begin
                  rd_data_d  = rom_data;
                  rd_valid_d = 1'b1;
               end
               pf_next_d = pf_take;
               if (accept && !pf_match) begin
                  pend_d      = 1'b1;
                  pend_addr_d = req_addr;
               end
            end else if (accept) begin
               if (pf_match) begin
                  pf_hit_d = 1'b1;
               end else begin
                  // Abort: drop the prefetch, honour the full gap, then serve.
                  rom_ce_n_d  = 1'b1;
                  tmr_load    = 1'b1;
                  tmr_val     = GAP_LOAD;
                  pend_d      = 1'b1;
                  pend_addr_d = req_addr;
                  pf_next_d   = 1'b0;
                  state_d     = StRec;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rom_addr_q  <= '0;
         rom_ce_n_q  <= 1'b1;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         pf_buf_q    <= '0;
         pf_addr_q   <= '0;
         pf_valid_q  <= 1'b0;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         pf_hit_q    <= 1'b0;
         pf_next_q   <= 1'b0;
         pf_drop_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rom_addr_q  <= rom_addr_d;
         rom_ce_n_q  <= rom_ce_n_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         pf_buf_q    <= pf_buf_d;
         pf_addr_q   <= pf_addr_d;
         pf_valid_q  <= pf_valid_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         pf_hit_q    <= pf_hit_d;
         pf_next_q   <= pf_next_d;
         pf_drop_q   <= pf_drop_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign rom_addr = rom_addr_q;
   assign rom_ce_n = rom_ce_n_q;

endmodule

// File: tb/tb_rom_reader.sv
// tb_rom_reader: self-checking bench for rom_reader with ACC_CYC=3, GAP_CYC=1.
// Expected responses are queued when a request is issued; a monitor pops and
// compares each rd_valid. Latency is predicted from a buffer model: once the
// controller is quiet, the buffer holds (last requested address + 1) unless an
// inval or reset has occurred since.
module tb_rom_reader;
   import rom_rd_pkg::*;

   localparam int ADDR_W   = 19;
   localparam int ACC_CYC  = 3;
   localparam int GAP_CYC  = 1;
   localparam int SETTLE   = 2 * (ACC_CYC + GAP_CYC) + 2;

   logic              fclk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic              inval = 1'b0;
   logic              ready;
   logic              rd_valid;
   logic [7:0]        rd_data;
   logic [ADDR_W-1:0] rom_addr;
   logic              rom_ce_n;
   logic [7:0]        rom_data;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
      int                lat;   // -1: latency not predicted
      int                acc;
   } exp_t;

   exp_t              sb[$];
   int                checks = 0;
   int                errors = 0;
   int                cyc = 0;
   int                lowcnt = 0;
   int                last_rdv = -1000;
   logic [ADDR_W-1:0] last_addr = '0;
   bit                buf_ok = 1'b0;

   function automatic logic [7:0] rom_byte(input logic [ADDR_W-1:0] a);
      logic [31:0] x;
      x = {13'd0, a} * 32'd2654435761;
      return x[23:16] ^ a[7:0];
   endfunction

   always #5 fclk = ~fclk;
   always @(posedge fclk) cyc <= cyc + 1;
   always @(posedge fclk) lowcnt <= rom_ce_n ? 0 : lowcnt + 1;

   // ROM model: data only valid once ce_n has been low for the full access time.
   assign rom_data = (!rom_ce_n && lowcnt >= ACC_CYC - 1) ? rom_byte(rom_addr) : 8'hEE;

   rom_reader #(
      .ADDR_W   (ADDR_W),
      .ACC_CYC  (ACC_CYC),
      .GAP_CYC  (GAP_CYC),
      .PREFETCH (1)
   ) dut (
      .fclk     (fclk),
      .rst_n    (rst_n),
      .req      (req),
      .req_addr (req_addr),
      .inval    (inval),
      .ready    (ready),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .rom_addr (rom_addr),
      .rom_ce_n (rom_ce_n),
      .rom_data (rom_data)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge fclk);
   endtask

   task automatic pulse_inval();
      @(negedge fclk);
      inval = 1'b1;
      @(negedge fclk);
      inval = 1'b0;
      buf_ok = 1'b0;
   endtask

   task automatic issue(input logic [ADDR_W-1:0] a, input int lat_ovr, input bit push,
                        input bit with_inv);
      int   n;
      bit   settled;
      exp_t e;
      n = 0;
      @(negedge fclk);
      while (ready !== 1'b1 && n < 100) begin
         @(negedge fclk);
         n++;
      end
      if (ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: ready=%b, required 1", ready);
         return;
      end
      settled = (sb.size() == 0) && (cyc - last_rdv >= SETTLE);
      e.addr = a;
      e.data = rom_byte(a);
      e.acc  = cyc + 1;
      if (lat_ovr != -2)    e.lat = lat_ovr;
      else if (settled)     e.lat = (buf_ok && !with_inv && a == last_addr + 19'd1) ? 0 : ACC_CYC;
      else                  e.lat = -1;
      if (push) begin
         sb.push_back(e);
         last_addr = a;
         buf_ok = 1'b1;
      end
      req = 1'b1;
      req_addr = a;
      inval = with_inv;
      @(posedge fclk);
      #2;
      req = 1'b0;
      inval = 1'b0;
   endtask

   // Monitor: scoreboard pops, response timeouts, rom_addr stability.
   initial begin : monitor
      exp_t              e;
      logic              prev_low;
      logic [ADDR_W-1:0] prev_addr;
      prev_low = 1'b0;
      prev_addr = '0;
      forever begin
         @(posedge fclk);
         #1;
         if (rd_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL spurious_rd_valid: rd_valid=1 data=%0h, required no response", rd_data);
            end else begin
               e = sb.pop_front();
               if (rd_data !== e.data) begin
                  errors++;
                  $display("FAIL rd_data @%0h: got %0h, required %0h", e.addr, rd_data, e.data);
               end
               if (e.lat >= 0) begin
                  checks++;
                  if (cyc - e.acc != e.lat) begin
                     errors++;
                     $display("FAIL latency @%0h: got %0d, required %0d", e.addr, cyc - e.acc, e.lat);
                  end
               end
            end
            last_rdv = cyc;
         end
         if (sb.size() > 0 && cyc - sb[0].acc > 60) begin
            checks++;
            errors++;
            $display("FAIL rd_valid_timeout @%0h: no response, required one", sb[0].addr);
            void'(sb.pop_front());
         end
         if (prev_low && rom_ce_n === 1'b0) begin
            checks++;
            if (rom_addr !== prev_addr) begin
               errors++;
               $display("FAIL rom_addr_stable: got %0h while ce_n low, required %0h", rom_addr,
                        prev_addr);
            end
         end
         prev_low = (rom_ce_n === 1'b0);
         prev_addr = rom_addr;
      end
   end

   initial begin : main
      int                n;
      int                g;
      int                r;
      logic [ADDR_W-1:0] a;
      logic [1:0]        pg;

      // Reset values.
      @(posedge fclk);
      #1;
      chk("reset_ready", ready, 1);
      chk("reset_ce_n", rom_ce_n, 1);
      chk("reset_rom_addr", rom_addr, 0);
      chk("reset_rd_valid", rd_valid, 0);
      chk("reset_rd_data", rd_data, 0);
      idle(2);
      rst_n = 1'b1;
      idle(2);

      // Miss from IDLE: access length, gap, prefetch address.
      issue(19'h04000, -2, 1'b1, 1'b0);
      n = 0;
      while (rom_ce_n === 1'b0 && n < 20) begin n++; @(posedge fclk); #2; end
      chk("acc_ce_low_clocks", n, ACC_CYC);
      g = 0;
      while (rom_ce_n === 1'b1 && g < 20) begin g++; @(posedge fclk); #2; end
      chk("gap_clocks", g, GAP_CYC);
      chk("prefetch_addr", rom_addr, 19'h04001);

      // Hit launches the next prefetch on the same edge.
      idle(12);
      issue(19'h04001, -2, 1'b1, 1'b0);
      chk("hit_pf_ce_low", rom_ce_n, 0);
      chk("hit_pf_addr", rom_addr, 19'h04002);

      // Other-address request during PFA aborts it.
      issue(19'h08000, ACC_CYC + GAP_CYC, 1'b1, 1'b0);
      chk("abort_ce_high", rom_ce_n, 1);
      idle(12);
      issue(19'h04002, -2, 1'b1, 1'b0);

      // Same-address request during PFA waits on the prefetch.
      idle(12);
      issue(19'h04001, -2, 1'b1, 1'b0);
      n = 0;
      while (!(rom_ce_n === 1'b0 && rom_addr === 19'h04002) && n < 40) begin
         n++; @(posedge fclk); #2;
      end
      chk("pfa_04002_seen", rom_addr, 19'h04002);
      issue(19'h04002, -2, 1'b1, 1'b0);
      chk("pfa_no_restart_ce", rom_ce_n, 0);
      chk("pfa_no_restart_addr", rom_addr, 19'h04002);
      idle(14);
      issue(19'h04003, -2, 1'b1, 1'b0);

      // Address wrap, then the same with an inval before the request.
      idle(12);
      issue(19'h7FFFF, -2, 1'b1, 1'b0);
      n = 0;
      while (!(rom_ce_n === 1'b0 && rom_addr !== 19'h7FFFF) && n < 40) begin
         n++; @(posedge fclk); #2;
      end
      chk("wrap_prefetch_addr", rom_addr, 19'h00000);
      idle(12);
      issue(19'h00000, -2, 1'b1, 1'b0);
      idle(12);
      issue(19'h7FFFF, -2, 1'b1, 1'b0);
      idle(12);
      pulse_inval();
      issue(19'h00000, ACC_CYC, 1'b1, 1'b0);

      // inval on the same edge as a would-be hit.
      idle(12);
      issue(19'h00001, ACC_CYC, 1'b1, 1'b1);

      // Reset during ACC: ce_n rises at once, no response, buffer emptied.
      idle(12);
      issue(19'h10000, -1, 1'b0, 1'b0);
      @(posedge fclk);
      #4;
      rst_n = 1'b0;
      #1;
      chk("rst_async_ce_n", rom_ce_n, 1);
      chk("rst_rd_valid", rd_valid, 0);
      @(posedge fclk);
      #4;
      rst_n = 1'b1;
      buf_ok = 1'b0;
      idle(12);
      chk("post_rst_ready", ready, 1);
      issue(19'h00002, ACC_CYC, 1'b1, 1'b0);

      // Randomised traffic.
      for (int i = 0; i < 60; i++) begin
         g = $urandom_range(0, 12);
         if (g > 0) idle(g);
         if ((sb.size() == 0) && (cyc - last_rdv >= SETTLE) && $urandom_range(0, 4) == 0) begin
            pulse_inval();
         end
         r = $urandom_range(0, 9);
         if (r < 5) begin
            a = last_addr + 19'd1;
         end else if (r < 8) begin
            pg = 2'($urandom_range(0, 3));
            unique case (pg)
               2'd0:    a = page_base(BAS48);
               2'd1:    a = page_base(TRDOS);
               2'd2:    a = page_base(BAS128);
               default: a = page_base(GLUK);
            endcase
            a = a | 19'($urandom_range(0, 16383));
         end else if (r == 8) begin
            a = 19'h7FFFF;
         end else begin
            a = last_addr;
         end
         issue(a, -2, 1'b1, ($urandom_range(0, 7) == 0));
      end

      n = 0;
      while (sb.size() > 0 && n < 300) begin n++; @(posedge fclk); #2; end
      chk("drain_queue", sb.size(), 0);
      idle(5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
